// File: rtl/s2_seq.sv
// s2_seq: sequencer for one s2neuron pass (clear, accumulate S operands, drain, done).
// Defining S2_FAULT_TIMEOUT_EN adds a consecutive-stall timeout that parks the block in ERR.
module s2_seq #(
    parameter int S   = 8,
    parameter int DL  = 1,
    parameter int TMO = 64,
    localparam int IW = (S > 1) ? $clog2(S) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          cfflag,
    output logic          en_s2,
    output logic          mac_clr,
    output logic [IW-1:0] idx,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    fault_cnt
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE, ERR} state_e;

    localparam logic [IW-1:0] IDX_LAST = IW'(S - 1);
    localparam logic [3:0]    DRN_LAST = 4'(DL - 1);

    if (S < 1 || DL < 1 || DL > 15 || TMO < 2 || TMO > 255) begin : gBadParam
        $error("s2_seq: parameter out of range");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    drn_q, drn_d;
    logic [7:0]    fcnt_q, fcnt_d;

`ifdef S2_FAULT_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TMO - 1);
    logic [7:0] stall_q, stall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drn_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drn_q   <= drn_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Abort outranks everything except reset; a stalled operand keeps idx so it is re-presented.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drn_d   = drn_q;
        fcnt_d  = fcnt_q;
`ifdef S2_FAULT_TIMEOUT_EN
        stall_d = stall_q;
`endif
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            drn_d   = '0;
`ifdef S2_FAULT_TIMEOUT_EN
            stall_d = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CLEAR;
                        idx_d   = '0;
                        fcnt_d  = '0;
                    end
                end
                CLEAR: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (cfflag) begin
                        if (fcnt_q != 8'hFF) begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
`ifdef S2_FAULT_TIMEOUT_EN
                        stall_d = stall_q + 8'd1;
                        if (stall_q == STALL_LAST) begin
                            state_d = ERR;
                            stall_d = '0;
                            idx_d   = '0;
                        end
`endif
                    end else begin
`ifdef S2_FAULT_TIMEOUT_EN
                        stall_d = '0;
`endif
                        if (idx_q == IDX_LAST) begin
                            state_d = DRAIN;
                            idx_d   = '0;
                            drn_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drn_q == DRN_LAST) begin
                        state_d = DONE;
                        drn_d   = '0;
                    end else begin
                        drn_d = drn_q + 4'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Strobes are masked during an abort cycle so the bank never sees a partial action.
    always_comb begin
        busy      = (state_q != IDLE);
        mac_clr   = (state_q == CLEAR) && !abort;
        en_s2     = (state_q == RUN) && !abort;
        done      = (state_q == DONE) && !abort;
        idx       = idx_q;
        fault_cnt = fcnt_q;
`ifdef S2_FAULT_TIMEOUT_EN
        err       = (state_q == ERR);
`else
        err       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_s2_seq.sv
// tb_s2_seq: directed and randomized checks of s2_seq against a pass-progress model.
// The S2_FAULT_TIMEOUT_EN build selects the timeout scenario instead of the long-stall one.
module tb_s2_seq;

    localparam int S   = 8;
    localparam int DL  = 1;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, cfflag;
    logic       en_s2, mac_clr, busy, done, err;
    logic [2:0] idx;
    logic [7:0] fault_cnt;

    int checkCount = 0;
    int errorCount = 0;

    s2_seq #(.S(S), .DL(DL), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cfflag(cfflag),
        .en_s2(en_s2), .mac_clr(mac_clr), .idx(idx), .busy(busy), .done(done),
        .err(err), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input bit cf);
        @(posedge clk);
        #1;
        start  = st;
        abort  = ab;
        cfflag = cf;
    endtask

    // Pass progress: has the clear happened, how many operands accepted, how many drain cycles done.
    bit mActive = 0, mCleared = 0, mErr = 0;
    int mAcc = 0, mDrained = 0, mFault = 0, mStall = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mActive <= 0; mCleared <= 0; mErr <= 0;
            mAcc <= 0; mDrained <= 0; mFault <= 0; mStall <= 0;
        end else if (!mActive) begin
            if (start) begin
                mActive <= 1; mCleared <= 0; mAcc <= 0; mDrained <= 0;
                mFault <= 0; mStall <= 0;
            end
        end else if (abort) begin
            mActive <= 0; mErr <= 0; mStall <= 0;
        end else if (mErr) begin
            mErr <= 1;
        end else if (!mCleared) begin
            mCleared <= 1;
        end else if (mAcc < S) begin
            if (cfflag) begin
                mFault <= (mFault < 255) ? mFault + 1 : 255;
                mStall <= mStall + 1;
`ifdef S2_FAULT_TIMEOUT_EN
                if (mStall + 1 == TMO) begin
                    mErr   <= 1;
                    mStall <= 0;
                end
`endif
            end else begin
                mStall <= 0;
                mAcc   <= mAcc + 1;
            end
        end else if (mDrained < DL) begin
            mDrained <= mDrained + 1;
        end else begin
            mActive <= 0;
        end
    end

    always @(negedge clk) begin
        bit clearNow, runNow, doneNow;
        int eIdx;
        clearNow = mActive && !mCleared;
        runNow   = mActive && mCleared && !mErr && (mAcc < S);
        doneNow  = mActive && !mErr && (mAcc == S) && (mDrained == DL);
        eIdx     = runNow ? mAcc : 0;
        checkOutput("busy", int'(busy), int'(mActive));
        checkOutput("mac_clr", int'(mac_clr), int'(clearNow && !abort));
        checkOutput("en_s2", int'(en_s2), int'(runNow && !abort));
        checkOutput("done", int'(done), int'(doneNow && !abort));
        checkOutput("err", int'(err), int'(mErr));
        checkOutput("idx", int'(idx), eIdx);
        checkOutput("fault_cnt", int'(fault_cnt), mFault);
    end

    // Cycle 0 carries the start pulse; counts are taken from outputs sampled at each negedge.
    task automatic runPass(input int startAt, input int abortAt, input int stallFrom,
                           input int stallLen, input int maxC,
                           output int doneAt, output int nDone, output int nClr,
                           output int nEn, output int nIdx4, output int nErr);
        doneAt = -1; nDone = 0; nClr = 0; nEn = 0; nIdx4 = 0; nErr = 0;
        for (int c = 0; c <= maxC; c++) begin
            applyStimulus(c == 0 || c == startAt, c == abortAt,
                          c >= stallFrom && c < stallFrom + stallLen);
            @(negedge clk);
            if (mac_clr) nClr++;
            if (en_s2) nEn++;
            if (en_s2 && idx == 3'd4) nIdx4++;
            if (err) nErr++;
            if (done) begin
                nDone++;
                if (doneAt < 0) doneAt = c;
            end
        end
        applyStimulus(0, 0, 0);
    endtask

    initial begin
        int doneAt, nDone, nClr, nEn, nIdx4, nErr;
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfflag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_idx", int'(idx), 0);
        checkOutput("rst_fault", int'(fault_cnt), 0);
        checkOutput("rst_strobes", int'({en_s2, mac_clr, done, err}), 0);
        reset = 1'b0;

        $display("[TB] fault-free pass");
        runPass(-1, -1, 100, 0, 20, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p1_doneAt", doneAt, 11);
        checkOutput("p1_nDone", nDone, 1);
        checkOutput("p1_nClr", nClr, 1);
        checkOutput("p1_nEn", nEn, 8);
        checkOutput("p1_fault", int'(fault_cnt), 0);

        $display("[TB] three-cycle stall at idx 4");
        runPass(-1, -1, 6, 3, 25, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p2_doneAt", doneAt, 14);
        checkOutput("p2_nIdx4", nIdx4, 4);
        checkOutput("p2_nEn", nEn, 11);
        checkOutput("p2_fault", int'(fault_cnt), 3);

        $display("[TB] start during RUN");
        runPass(4, -1, 100, 0, 20, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p3_doneAt", doneAt, 11);
        checkOutput("p3_nClr", nClr, 1);
        checkOutput("p3_fault_cleared", int'(fault_cnt), 0);

        $display("[TB] abort during DRAIN");
        runPass(-1, 10, 100, 0, 20, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p4_nDone", nDone, 0);
        checkOutput("p4_busy", int'(busy), 0);

        $display("[TB] reset mid-pass");
        applyStimulus(1, 0, 0);
        for (int c = 1; c <= 7; c++) applyStimulus(0, 0, 0);
        #2;
        checkOutput("p5_idxBefore", int'(idx), 5);
        reset = 1'b1;
        #1;
        checkOutput("p5_idxReset", int'(idx), 0);
        checkOutput("p5_busyReset", int'(busy), 0);
        checkOutput("p5_enReset", int'(en_s2), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("p5_noResume", int'(busy), 0);
        runPass(-1, -1, 100, 0, 20, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p5_doneAt", doneAt, 11);

`ifdef S2_FAULT_TIMEOUT_EN
        $display("[TB] stall timeout into ERR then abort");
        runPass(-1, 70, 2, 68, 75, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p6_nEn", nEn, 64);
        checkOutput("p6_nErr", nErr, 5);
        checkOutput("p6_nDone", nDone, 0);
        checkOutput("p6_errAfter", int'(err), 0);
        checkOutput("p6_busyAfter", int'(busy), 0);
`else
        $display("[TB] 300-cycle stall saturates fault_cnt");
        runPass(-1, -1, 2, 300, 320, doneAt, nDone, nClr, nEn, nIdx4, nErr);
        checkOutput("p6_doneAt", doneAt, 311);
        checkOutput("p6_nErr", nErr, 0);
        checkOutput("p6_fault", int'(fault_cnt), 255);
        checkOutput("p6_nEn", nEn, 308);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit st, ab, cf, rs;
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 39) == 0);
            cf = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 299) == 0);
            applyStimulus(st, ab, cf);
            reset = rs;
        end
        applyStimulus(0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
